data_change_logger: RTL and testbench
=====================================

// Module: data_change_logger
// PURPOSE
//   Observer for a narrow register bus: samples data_in every clk, detects value changes,
//   records each change as a {timestamp, value} entry in a small FIFO drained by a
//   valid/ready reader. Sits beside latch/flip-flop exercises as the hardware counterpart of
//   a $monitor: consumes what a blocking/nonblocking writer produces and replays its history.
// PARAMETERS
//   DATA_W  4   width of the observed bus and of logged values
//   TS_W    16  width of the free-running timestamp counter and of logged timestamps
//   DEPTH   8   FIFO entries; power of two, >= 2
// PORTS
//   clk       in   1              rising-edge clock
//   rst_n     in   1              asynchronous active-low reset
//   en        in   1              1 = compare/log enabled; 0 = sampling frozen, no logging
//   clear     in   1              synchronous flush: FIFO, overflow, timestamp, baseline
//   data_in   in   DATA_W         observed bus, synchronous to clk
//   rd_valid  out  1              head entry available
//   rd_ready  in   1              reader accepts head entry this cycle
//   rd_value  out  DATA_W         logged value of head entry
//   rd_time   out  TS_W           logged timestamp of head entry
//   count     out  $clog2(DEPTH)+1  entries currently stored
//   overflow  out  1              sticky: a change was dropped because FIFO was full
// BEHAVIOUR
//   - Reset (async, rst_n=0): rd_valid=0, rd_value=0, rd_time=0, count=0, overflow=0,
//     timestamp=0, prev=0, armed=0. Release takes effect on first clk edge with rst_n=1.
//   - Timestamp: increments every clk edge regardless of en; wraps 2^TS_W-1 -> 0; wrap is
//     not an event.
//   - Baseline: first edge with en=1 and armed=0 loads prev<=data_in, sets armed=1, logs nothing.
//   - Change: edge with en=1, armed=1, data_in!=prev -> push {timestamp, data_in}; prev<=data_in.
//     Timestamp logged is the counter value before that edge's increment.
//   - Latency: change sampled at edge N into empty FIFO -> rd_valid=1 after edge N (one cycle).
//   - Pop: rd_valid & rd_ready at an edge removes head; outputs show next entry after edge.
//   - Full: push with count==DEPTH and no pop -> entry dropped, overflow<=1, prev still updates.
//   - Full with simultaneous pop and push: both accepted, count stays DEPTH, overflow unchanged.
//   - Empty with simultaneous push and rd_ready: no bypass; entry stored, rd_valid next cycle.
//   - en=0: prev and armed hold; changes during en=0 are not logged; on re-enable the first
//     compare is against the held prev.
//   - clear=1 (priority over push/pop): count=0, rd_valid=0, overflow=0, timestamp=0, armed=0.
//   - Outputs rd_value/rd_time are registered FIFO head; undefined content is masked to 0 when
//     rd_valid=0.
// CONFIGURATION
//   CHG_LOG_DELTA_EN defined: rd_time carries cycles since previous logged change (first entry
//     after reset/clear: cycles since baseline), saturating at 2^TS_W-1; a dropped entry does not
//     reset the delta reference.
//   Not defined: rd_time is the absolute wrapping timestamp as above.
// STRUCTURE
//   Package chg_log_pkg: DATA_W/TS_W defaults, ENTRY_W=DATA_W+TS_W, entry pack/unpack macros
//   or functions {time, value}.
//   Sub-module sync_fifo (width ENTRY_W, depth DEPTH, push/pop/flush, count, full, empty);
//   detector, timestamp counter and overflow flag live in data_change_logger.
// TESTING
//   1 Reset, en=1, data_in held 4'h4 for 10 cycles -> no entries, count=0, overflow=0.
//   2 Baseline 4'h4, data_in->5 at ts 3, ->10 at ts 5, rd_ready=1 -> entries (3,5),(5,10) in
//     order, each rd_valid one cycle after its edge.
//   3 rd_ready=0, toggle data_in 0/1 for DEPTH+2 changes -> count=8, overflow=1, first 8 values
//     retained; then drain -> count=0, overflow stays 1 until clear.
//   4 FIFO full, rd_ready=1 and change same edge -> count stays 8, overflow stays 0.
//   5 TS_W=4: change at counter 15 then at 1 -> rd_time 15 then 1 (absolute); with
//     CHG_LOG_DELTA_EN -> second entry rd_time 2.
//   6 Assert rst_n=0 mid-burst with 3 entries, then clear mid-burst in a second run ->
//     rd_valid=0, count=0 immediately (async) / next edge (clear); next change re-baselines.

Source files
------------

// File: rtl/chg_log_pkg.sv
// Shared widths and {time, value} entry packing for data_change_logger.
// Entry macros take explicit widths so they serve any parameterisation of the logger.
package chg_log_pkg;
    localparam int DATA_W_DEF  = 4;
    localparam int TS_W_DEF    = 16;
    localparam int DEPTH_DEF   = 8;
    localparam int ENTRY_W_DEF = DATA_W_DEF + TS_W_DEF;
endpackage

`ifndef CHG_LOG_ENTRY_MACROS
`define CHG_LOG_ENTRY_MACROS
`define CHG_LOG_PACK(t, v) {(t), (v)}
`define CHG_LOG_VALUE(e, dw) e[(dw)-1:0]
`define CHG_LOG_TIME(e, dw, tw) e[(dw)+(tw)-1:(dw)]
`endif

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; head data is masked to zero while empty.
// A pop frees a slot in the same edge, so a full FIFO accepts a simultaneous push and pop.
module sync_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

    // NOTE: storage has no reset; stale slots are never visible because rdata is masked when empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/data_change_logger.sv
// Logs every change of data_in as a {timestamp, value} entry into a FIFO read via valid/ready.
// Define CHG_LOG_DELTA_EN to log saturating cycles since the previous logged change instead.
module data_change_logger
    import chg_log_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int TS_W   = TS_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     clear,
    input  logic [DATA_W-1:0]        data_in,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [DATA_W-1:0]        rd_value,
    output logic [TS_W-1:0]          rd_time,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    localparam int ENTRY_W = DATA_W + TS_W;

    logic [TS_W-1:0]    ts;
    logic [TS_W-1:0]    log_time;
    logic [DATA_W-1:0]  prev;
    logic               armed;
    logic               change;
    logic               pop;
    logic               drop;
    logic               full;
    logic               empty;
    logic [ENTRY_W-1:0] head;

    assign change   = en && armed && (data_in != prev);
    assign pop      = rd_valid && rd_ready;
    assign drop     = change && full && !pop;
    assign rd_valid = !empty;
    assign rd_value = `CHG_LOG_VALUE(head, DATA_W);
    assign rd_time  = `CHG_LOG_TIME(head, DATA_W, TS_W);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts       <= '0;
            prev     <= '0;
            armed    <= 1'b0;
            overflow <= 1'b0;
        end else if (clear) begin
            ts       <= '0;
            prev     <= '0;
            armed    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            ts <= ts + 1'b1;
            if (en && !armed) begin
                prev  <= data_in;
                armed <= 1'b1;
            end else if (change) begin
                prev <= data_in;
            end
            if (drop) overflow <= 1'b1;
        end
    end

`ifdef CHG_LOG_DELTA_EN
    // Delta reference restarts at baseline and on accepted entries only, never on drops.
    logic [TS_W-1:0] delta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            delta <= '0;
        else if (clear)
            delta <= '0;
        else if ((en && !armed) || (change && !drop))
            delta <= TS_W'(1);
        else if (delta != '1)
            delta <= delta + 1'b1;
    end

    assign log_time = delta;
`else
    assign log_time = ts;
`endif

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (clear),
        .push  (change),
        .pop   (pop),
        .wdata (`CHG_LOG_PACK(log_time, data_in)),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );
endmodule

// File: tb/tb_data_change_logger.sv
// Directed bench for data_change_logger (default absolute-timestamp build) plus a TS_W=4 instance.
module tb_data_change_logger;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  data_in = 4'h0;
    logic        rd_ready = 1'b0;

    logic        rd_valid, overflow;
    logic [3:0]  rd_value;
    logic [15:0] rd_time;
    logic [3:0]  count;

    logic        rd_valid2, overflow2;
    logic [3:0]  rd_value2;
    logic [3:0]  rd_time2;
    logic [3:0]  count2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_change_logger dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .data_in(data_in),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_value(rd_value),
        .rd_time(rd_time), .count(count), .overflow(overflow)
    );

    data_change_logger #(.DATA_W(4), .TS_W(4), .DEPTH(8)) dut_ts4 (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .data_in(data_in),
        .rd_valid(rd_valid2), .rd_ready(rd_ready), .rd_value(rd_value2),
        .rd_time(rd_time2), .count(count2), .overflow(overflow2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One rising edge; returns at the following falling edge for sampling and driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_valid", rd_valid, 0);
        check("rst_count", count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_value", rd_value, 0);
        check("rst_time", rd_time, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        // 1: constant bus logs nothing
        do_reset();
        en = 1'b1;
        data_in = 4'h4;
        for (int i = 0; i < 10; i++) step();
        check("t1_count", count, 0);
        check("t1_valid", rd_valid, 0);
        check("t1_ovf", overflow, 0);

        // 2: entries (3,5) then (5,10), each visible one cycle after its edge
        do_reset();
        rd_ready = 1'b1;
        data_in = 4'h4;
        step(); step(); step();            // ts 0 baseline, ts 1, ts 2
        data_in = 4'h5;
        step();                            // ts 3 change
        check("t2_valid0", rd_valid, 1);
        check("t2_value0", rd_value, 5);
        check("t2_time0", rd_time, 3);
        step();                            // ts 4 pops
        check("t2_empty", rd_valid, 0);
        data_in = 4'hA;
        step();                            // ts 5 change
        check("t2_value1", rd_value, 10);
        check("t2_time1", rd_time, 5);
        step();                            // ts 6 pops
        check("t2_count", count, 0);

        // 3: overflow with 10 changes into 8 slots, then drain
        rd_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin // ts 7..16
            data_in = 4'(i % 2);
            step();
        end
        check("t3_count", count, 8);
        check("t3_ovf", overflow, 1);
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin  // ts 17..24
            check("t3_value", rd_value, i % 2);
            check("t3_time", rd_time, 7 + i);
            step();
        end
        check("t3_drained", count, 0);
        check("t3_ovf_sticky", overflow, 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("t3_clr_ovf", overflow, 0);
        check("t3_clr_count", count, 0);

        // 4: full FIFO with simultaneous pop and push
        rd_ready = 1'b0;
        step();                            // ts 0 baseline on 1
        for (int i = 0; i < 8; i++) begin  // ts 1..8
            data_in = 4'(i % 2);
            step();
        end
        check("t4_full", count, 8);
        rd_ready = 1'b1;
        data_in = 4'h0;
        step();                            // ts 9 pop + push
        rd_ready = 1'b0;
        check("t4_count", count, 8);
        check("t4_ovf", overflow, 0);
        check("t4_head_value", rd_value, 1);
        check("t4_head_time", rd_time, 2);

        // 5: TS_W=4 wrap: changes at counter 15 and 1
        do_reset();
        data_in = 4'h4;
        for (int i = 0; i < 15; i++) step(); // ts 0..14
        data_in = 4'h7;
        step();                            // ts 15
        step();                            // ts 16 (narrow: 0)
        data_in = 4'h2;
        step();                            // ts 17 (narrow: 1)
        check("t5_time_a", rd_time2, 15);
        check("t5_wide_a", rd_time, 15);
        rd_ready = 1'b1;
        step();                            // ts 18 pop
        rd_ready = 1'b0;
        check("t5_time_b", rd_time2, 1);
        check("t5_value_b", rd_value2, 2);
        check("t5_wide_b", rd_time, 17);

        // 6: async reset with 3 entries, then clear mid-burst
        data_in = 4'h3;
        step();                            // ts 19
        data_in = 4'h4;
        step();                            // ts 20
        check("t6_three", count, 3);
        do_reset();
        data_in = 4'h9;
        step();                            // ts 0 baseline on 9
        check("t6_rebase", count, 0);
        step();                            // ts 1
        data_in = 4'h6;
        step();                            // ts 2
        check("t6_time", rd_time, 2);
        check("t6_value", rd_value, 6);
        for (int i = 1; i <= 3; i++) begin // ts 3..5
            data_in = 4'(i);
            step();
        end
        check("t6_four", count, 4);
        clear = 1'b1;
        data_in = 4'h5;
        step();
        clear = 1'b0;
        check("t6_clr_count", count, 0);
        check("t6_clr_valid", rd_valid, 0);
        step();                            // ts 0 baseline on 5
        check("t6_clr_rebase", count, 0);
        data_in = 4'h8;
        step();                            // ts 1
        check("t6_clr_time", rd_time, 1);
        check("t6_clr_value", rd_value, 8);

        // en=0 freezes baseline; re-enable compares against held value
        rd_ready = 1'b1;
        step();                            // ts 2 pop
        rd_ready = 1'b0;
        en = 1'b0;
        data_in = 4'h2;
        step();                            // ts 3
        data_in = 4'h8;
        step();                            // ts 4
        check("en0_count", count, 0);
        en = 1'b1;
        step();                            // ts 5, equals held prev
        check("en1_nochange", count, 0);
        data_in = 4'h2;
        step();                            // ts 6
        check("en1_time", rd_time, 6);
        check("en1_value", rd_value, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
